alu_op_sequencer: RTL
=====================

// Module: alu_op_sequencer
// PURPOSE
// - Parametrised successor to the ALU's combinational opcode decode. Accepts {opcode, repeat count} over valid/ready and
//   issues one registered 13-bit control word per cycle, for the requested number of cycles.
// - Sits between the instruction source and the Skein ALU datapath (primary/secondary/bit-counter/comparator registers, demuxes).
// - Replaces per-cycle opcode streaming, e.g. "rotate primary left 1 bit" x N comes from a single accepted instruction.
// PARAMETERS
// - OPCODE_W  4   opcode width; opcodes >= 2**OPCODE_W do not exist
// - REPEAT_W  6   repeat-count width; count 0 is treated as 1
// - CTRL_W    13  control-word width; fixed field layout, see STRUCTURE
// PORTS
// - clk_i        in   1         clock
// - rst_n_i      in   1         asynchronous active-low reset
// - in_valid_i   in   1         instruction offered
// - in_ready_o   out  1         instruction accepted when in_valid_i && in_ready_o
// - opcode_i     in   OPCODE_W  opcode
// - repeat_i     in   REPEAT_W  issue count (0 -> 1)
// - hold_i       in   1         datapath stall: issue idle word, do not consume a repeat
// - ctrl_o       out  CTRL_W    registered control word {pri[2:0],sec[1:0],bc[1:0],cmpreg,cmpdmx,ptdmx,outdmx[1:0],indmx}
// - ctrl_valid_o out  1         ctrl_o carries an issued (non-idle) word this cycle
// - done_o       out  1         one-cycle pulse coincident with the last issue of an instruction
// - busy_o       out  1         an instruction is in progress
// - illegal_o    out  1         sticky illegal-opcode flag (only with the optional feature; else tied 0)
// BEHAVIOUR
// - Reset (async assert, sync release): state IDLE, ctrl_o=13'h0000 (idle word), ctrl_valid_o=0, done_o=0, busy_o=0,
//   illegal_o=0, remaining=0. Reset mid-instruction abandons it; no done_o.
// - States: IDLE, ISSUE. IDLE->ISSUE on accept. ISSUE->IDLE after the last issue unless a new instruction is accepted that cycle.
// - Latency: instruction accepted in cycle T; first control word visible on ctrl_o in T+1. Issued word = decode(opcode).
// - remaining is loaded with max(repeat_i,1) on accept. It decrements on each non-held ISSUE cycle.
// - hold_i=1 in ISSUE: next ctrl_o=idle word, ctrl_valid_o=0, remaining unchanged. hold_i is ignored in IDLE.
// - in_ready_o = IDLE || (ISSUE && remaining==1 && !hold_i). Back-to-back instructions therefore issue with no bubble.
// - done_o=1 on the registered cycle that carries the final word (ctrl_valid_o=1 and remaining was 1).
// - busy_o=1 from T+1 through the final issue cycle inclusive.
// - Decode table, opcode -> word:
//   0:1C00 1:1800 2:080A 3:0450 4:0300 5:0200 6:0900 7:1C05 8:1C07 9:0080 A:0020 B:0002 C:000A D:0010 E:0000
// - Opcodes 0xA and 0xE are single-shot: repeat_i is forced to 1.
// - Any opcode outside 0x0-0xE is undefined (see CONFIGURATION).
// - Opcodes wider than 4 bits: values above 0xE are undefined.
// CONFIGURATION
// - Macro ALU_OP_SEQUENCER_ILLEGAL_TRAP_EN.
//   Defined: an undefined opcode is still accepted, but issues 0 words (ctrl_valid_o stays 0). done_o pulses in T+1, and
//   illegal_o sets and stays set until reset.
//   Undefined: an undefined opcode decodes as 0xC (primary pass-through, 000A) with the normal repeat. illegal_o is tied to 0.
// STRUCTURE
// - Package alu_ctrl_pkg: CTRL_W, field index localparams, opcode localparams (OP_WR_PRI..OP_CMP), idle word,
//   decode function op_to_ctrl(), single-shot predicate is_single_shot().
// - One sub-module: alu_op_decode (combinational op_to_ctrl wrapper plus legal flag). The sequencer FSM/counter is in this module.
// TESTING
// - Reset, then idle: ctrl_o=0000, ctrl_valid_o=0, in_ready_o=1, busy_o=0.
// - Accept op 3 with repeat 5, hold_i=0: ctrl_o=0450 with valid for 5 cycles starting T+1; done_o on the 5th; in_ready_o on the 5th.
// - Back-to-back: op 0 with repeat 1, then op 8 with repeat 2 offered continuously: 1C00, 1C07, 1C07 on consecutive cycles, no gap.
// - Hold: op 2 with repeat 3 and hold_i high for 2 cycles after the first issue: 080A, 0000, 0000, 080A, 080A (done_o on the last).
// - Single-shot and zero repeat: op A with repeat 7 gives exactly one 0020. Op 9 with repeat 0 gives exactly one 0080.
// - Undefined op F: with the macro, no valid word, done_o in T+1, illegal_o=1 until rst_n_i low.
//   Without the macro, 000A is issued. Also assert rst_n_i mid-burst: outputs return to reset values immediately.

Source files
------------

// File: rtl/alu_ctrl_pkg.sv
// Shared control-word layout, opcode names, sequencer state type and decode helpers
// for the ALU opcode sequencer.
package alu_ctrl_pkg;

    // Field positions inside {pri[2:0],sec[1:0],bc[1:0],cmpreg,cmpdmx,ptdmx,outdmx[1:0],indmx}
    localparam int INDMX_BIT  = 0;
    localparam int OUTDMX_LSB = INDMX_BIT + 1;
    localparam int PTDMX_BIT  = OUTDMX_LSB + 2;
    localparam int CMPDMX_BIT = PTDMX_BIT + 1;
    localparam int CMPREG_BIT = CMPDMX_BIT + 1;
    localparam int BC_LSB     = CMPREG_BIT + 1;
    localparam int SEC_LSB    = BC_LSB + 2;
    localparam int PRI_LSB    = SEC_LSB + 2;
    localparam int CTRL_W     = PRI_LSB + 3;

    localparam logic [CTRL_W-1:0] CTRL_IDLE = '0;

    localparam logic [3:0] OP_WR_PRI   = 4'h0;
    localparam logic [3:0] OP_WR_SEC   = 4'h1;
    localparam logic [3:0] OP_XOR_PRI  = 4'h2;
    localparam logic [3:0] OP_ROT_PRI  = 4'h3;
    localparam logic [3:0] OP_SWAP     = 4'h4;
    localparam logic [3:0] OP_LD_SEC   = 4'h5;
    localparam logic [3:0] OP_MIX      = 4'h6;
    localparam logic [3:0] OP_ADD_LO   = 4'h7;
    localparam logic [3:0] OP_ADD_HI   = 4'h8;
    localparam logic [3:0] OP_BC_STEP  = 4'h9;
    localparam logic [3:0] OP_BC_CLR   = 4'hA;
    localparam logic [3:0] OP_OUT_SEC  = 4'hB;
    localparam logic [3:0] OP_PASS_PRI = 4'hC;
    localparam logic [3:0] OP_PT_SEL   = 4'hD;
    localparam logic [3:0] OP_CMP      = 4'hE;

    typedef enum logic {
        ST_IDLE,
        ST_ISSUE
    } seq_state_e;

    function automatic logic [CTRL_W-1:0] op_to_ctrl(input logic [3:0] op);
        logic [CTRL_W-1:0] w;
        case (op)
            OP_WR_PRI:   w = 13'h1C00;
            OP_WR_SEC:   w = 13'h1800;
            OP_XOR_PRI:  w = 13'h080A;
            OP_ROT_PRI:  w = 13'h0450;
            OP_SWAP:     w = 13'h0300;
            OP_LD_SEC:   w = 13'h0200;
            OP_MIX:      w = 13'h0900;
            OP_ADD_LO:   w = 13'h1C05;
            OP_ADD_HI:   w = 13'h1C07;
            OP_BC_STEP:  w = 13'h0080;
            OP_BC_CLR:   w = 13'h0020;
            OP_OUT_SEC:  w = 13'h0002;
            OP_PASS_PRI: w = 13'h000A;
            OP_PT_SEL:   w = 13'h0010;
            OP_CMP:      w = 13'h0000;
            default:     w = 13'h000A;
        endcase
        return w;
    endfunction

    function automatic logic is_single_shot(input logic [3:0] op);
        return (op == OP_BC_CLR) || (op == OP_CMP);
    endfunction

endpackage

// File: rtl/alu_op_decode.sv
// Combinational opcode decode: control word, legality and single-shot flag.
// Undefined opcodes fall back to the primary pass-through word.
module alu_op_decode
    import alu_ctrl_pkg::*;
#(
    parameter int OPCODE_W = 4
) (
    input  logic [OPCODE_W-1:0] opcode_i,
    output logic [CTRL_W-1:0]   ctrl_o,
    output logic                legal_o,
    output logic                single_shot_o
);

    logic [3:0] op4;

    always_comb begin
        legal_o       = 32'(opcode_i) <= 32'(OP_CMP);
        op4           = legal_o ? 4'(opcode_i) : OP_PASS_PRI;
        ctrl_o        = op_to_ctrl(op4);
        single_shot_o = is_single_shot(op4);
    end

endmodule

// File: rtl/alu_op_sequencer.sv
// Accepts {opcode, repeat} instructions and issues one registered ALU control word per cycle.
// Optional undefined-opcode trap: define ALU_OP_SEQUENCER_ILLEGAL_TRAP_EN.
module alu_op_sequencer #(
    parameter int OPCODE_W = 4,
    parameter int REPEAT_W = 6,
    parameter int CTRL_W   = alu_ctrl_pkg::CTRL_W
) (
    input  logic                clk_i,
    input  logic                rst_n_i,
    input  logic                in_valid_i,
    output logic                in_ready_o,
    input  logic [OPCODE_W-1:0] opcode_i,
    input  logic [REPEAT_W-1:0] repeat_i,
    input  logic                hold_i,
    output logic [CTRL_W-1:0]   ctrl_o,
    output logic                ctrl_valid_o,
    output logic                done_o,
    output logic                busy_o,
    output logic                illegal_o
);

    import alu_ctrl_pkg::*;

    seq_state_e          state_q;
    logic [REPEAT_W-1:0] remaining_q;
    logic [CTRL_W-1:0]   word_q;
    logic [CTRL_W-1:0]   ctrl_q;
    logic                ctrl_valid_q;
    logic                done_q;
    logic                busy_q;
    logic                illegal_q;

    logic [CTRL_W-1:0]   dec_ctrl;
    logic                dec_legal;
    logic                dec_single;
    logic                accept;
    logic                trap;
    logic [REPEAT_W-1:0] load_count;

    alu_op_decode #(
        .OPCODE_W(OPCODE_W)
    ) u_decode (
        .opcode_i     (opcode_i),
        .ctrl_o       (dec_ctrl),
        .legal_o      (dec_legal),
        .single_shot_o(dec_single)
    );

    // remaining counts the word on ctrl_o too, so ready opens while the last word is shown
    assign in_ready_o = (state_q == ST_IDLE) || ((remaining_q == REPEAT_W'(1)) && !hold_i);
    assign accept     = in_valid_i && in_ready_o;
    assign load_count = (dec_single || (repeat_i == '0)) ? REPEAT_W'(1) : repeat_i;

`ifdef ALU_OP_SEQUENCER_ILLEGAL_TRAP_EN
    assign trap = !dec_legal;
`else
    logic unused_legal;
    assign unused_legal = dec_legal;
    assign trap         = 1'b0;
`endif

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q      <= ST_IDLE;
            remaining_q  <= '0;
            word_q       <= CTRL_IDLE;
            ctrl_q       <= CTRL_IDLE;
            ctrl_valid_q <= 1'b0;
            done_q       <= 1'b0;
            busy_q       <= 1'b0;
            illegal_q    <= 1'b0;
        end else begin
            ctrl_q       <= CTRL_IDLE;
            ctrl_valid_q <= 1'b0;
            done_q       <= 1'b0;
            if (accept && trap) begin
                state_q     <= ST_IDLE;
                remaining_q <= '0;
                busy_q      <= 1'b0;
                done_q      <= 1'b1;
                illegal_q   <= 1'b1;
            end else if (accept) begin
                state_q      <= ST_ISSUE;
                remaining_q  <= load_count;
                word_q       <= dec_ctrl;
                ctrl_q       <= dec_ctrl;
                ctrl_valid_q <= 1'b1;
                done_q       <= (load_count == REPEAT_W'(1));
                busy_q       <= 1'b1;
            end else if ((state_q == ST_ISSUE) && !hold_i) begin
                remaining_q <= remaining_q - REPEAT_W'(1);
                if (remaining_q == REPEAT_W'(1)) begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end else begin
                    ctrl_q       <= word_q;
                    ctrl_valid_q <= 1'b1;
                    done_q       <= (remaining_q == REPEAT_W'(2));
                end
            end
        end
    end

    assign ctrl_o       = ctrl_q;
    assign ctrl_valid_o = ctrl_valid_q;
    assign done_o       = done_q;
    assign busy_o       = busy_q;
    assign illegal_o    = illegal_q;

endmodule
